// File: rtl/riscv_lsu.sv
// Load/store unit: turns one core load/store into a single access on the RAM data port.
// Optional misaligned-access trap is enabled with `define LSU_MISALIGN_TRAP_EN.
module riscv_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  output logic              err_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              misalign;
  logic              accept;
  logic [3:0]        be_raw;
  logic [DATA_W-1:0] load_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // size[1:0]: 00 byte, 01 half, 1x word (covers funct3 2/3/6/7)
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (core_size_i[1:0] == 2'b01)
      misalign = core_addr_i[0];
    else if (core_size_i[1])
      misalign = (core_addr_i[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign accept = core_req_i && !misalign;

  always_comb begin
    be_raw   = 4'b1111;
    mem_wd_o = core_wd_i;
    case (core_size_i[1:0])
      2'b00: begin
        be_raw   = 4'b0001 << core_addr_i[1:0];
        mem_wd_o = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        be_raw   = 4'b0011 << {core_addr_i[1], 1'b0};
        mem_wd_o = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_raw   = 4'b1111;
        mem_wd_o = core_wd_i;
      end
    endcase
  end

  assign mem_addr_o = {core_addr_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    ld_byte   = mem_rd_i[{off_q, 3'b000} +: 8];
    ld_half   = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    load_data = mem_rd_i;
    case (size_q[1:0])
      2'b00:   load_data = {{24{ld_byte[7]  & ~size_q[2]}}, ld_byte};
      2'b01:   load_data = {{16{ld_half[15] & ~size_q[2]}}, ld_half};
      default: load_data = mem_rd_i;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          off_d   = core_addr_i[1:0];
          size_d  = core_size_i;
          we_d    = core_we_i;
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (!we_q)
          hold_d = load_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    core_stall_o = 1'b0;
    err_o        = 1'b0;
    core_rd_o    = hold_q;
    case (state_q)
      IDLE: begin
        mem_req_o    = accept;
        mem_we_o     = accept && core_we_i;
        mem_be_o     = accept ? be_raw : 4'b0000;
        core_stall_o = accept;
        err_o        = core_req_i && misalign;
      end
      WAIT: begin
        if (!we_q)
          core_rd_o = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu with a byte-enabled, registered-read RAM model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] ram [0:63];
  logic [31:0] exp_q [$];

  riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered read, byte-enabled write
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o[7:2]][b*8 +: 8] <= mem_wd_o[b*8 +: 8];
      end else begin
        mem_rd_i <= ram[mem_addr_o[7:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a load completes in the cycle after the DUT issues a read request
  initial begin : monitor
    logic        pend;
    logic [31:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
        exp_q.delete();
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_load actual=%h required=none", core_rd_o);
          end else begin
            e = exp_q.pop_front();
            chk("load_result", core_rd_o, e);
          end
        end
        pend = mem_req_o && !mem_we_o;
      end
    end
  end

  task automatic access(input string name, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_addr, input logic [31:0] exp_rd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    if (!we) exp_q.push_back(exp_rd);
    @(negedge clk);
    chk({name, "_stall"},   {31'd0, core_stall_o}, 32'd1);
    chk({name, "_req"},     {31'd0, mem_req_o},    32'd1);
    chk({name, "_we"},      {31'd0, mem_we_o},     {31'd0, we});
    chk({name, "_be"},      {28'd0, mem_be_o},     {28'd0, exp_be});
    chk({name, "_addr"},    mem_addr_o,            exp_addr);
    chk({name, "_err"},     {31'd0, err_o},        32'd0);
    if (we) chk({name, "_wd"}, mem_wd_o, exp_wd);
    @(posedge clk);
    #1;
    core_req_i = 1'b0;
    @(negedge clk);
    chk({name, "_wait_stall"}, {31'd0, core_stall_o}, 32'd0);
    chk({name, "_wait_req"},   {31'd0, mem_req_o},    32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4'h4] = 32'hA1B2C3F4;   // byte address 0x10
    mem_rd_i    = 32'h0;
    reset       = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    #3;
    chk("rst_rd",    core_rd_o,               32'h0);
    chk("rst_stall", {31'd0, core_stall_o},   32'd0);
    chk("rst_req",   {31'd0, mem_req_o},      32'd0);
    chk("rst_we",    {31'd0, mem_we_o},       32'd0);
    chk("rst_be",    {28'd0, mem_be_o},       32'd0);
    chk("rst_err",   {31'd0, err_o},          32'd0);
    #19 reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_req",   {31'd0, mem_req_o},    32'd0);
    chk("idle_stall", {31'd0, core_stall_o}, 32'd0);
    @(posedge clk);
    #1;

    access("lb13",  1'b0, 3'd0, 32'h13, 32'h0, 4'b1000, 32'h0, 32'h10, 32'hFFFFFFA1);
    access("lbu12", 1'b0, 3'd4, 32'h12, 32'h0, 4'b0100, 32'h0, 32'h10, 32'h000000B2);
    access("lh12",  1'b0, 3'd1, 32'h12, 32'h0, 4'b1100, 32'h0, 32'h10, 32'hFFFFA1B2);
    access("lhu10", 1'b0, 3'd5, 32'h10, 32'h0, 4'b0011, 32'h0, 32'h10, 32'h0000C3F4);
    access("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h10, 32'hA1B2C3F4);

    c0 = cyc;
    access("b2b0", 1'b0, 3'd2, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h10, 32'hA1B2C3F4);
    access("b2b1", 1'b0, 3'd2, 32'h20, 32'h0, 4'b1111, 32'h0, 32'h20, 32'h00000000);
    access("b2b2", 1'b0, 3'd2, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h10, 32'hA1B2C3F4);
    chk("b2b_cycles", cyc - c0, 32'd6);

    access("sb21", 1'b1, 3'd0, 32'h21, 32'h1234565A, 4'b0010, 32'h5A5A5A5A, 32'h20, 32'h0);
    access("sh22", 1'b1, 3'd1, 32'h22, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h20, 32'h0);
    access("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 4'b1111, 32'h0, 32'h20, 32'hBEEF5A00);

    // store after load: the store's WAIT and subsequent idle keep the load value
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = 3'd0;
    core_addr_i = 32'h23;
    core_wd_i   = 32'h00000077;
    @(negedge clk);
    chk("hold_st_be", {28'd0, mem_be_o}, 32'h8);
    @(posedge clk);
    #1;
    core_req_i = 1'b0;
    @(negedge clk);
    chk("hold_st_wait", core_rd_o, 32'hBEEF5A00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_idle", core_rd_o, 32'hBEEF5A00);
    end
    @(posedge clk);
    #1;
    access("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 4'b1111, 32'h0, 32'h20, 32'h77EF5A00);

`ifdef LSU_MISALIGN_TRAP_EN
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h11;
    @(negedge clk);
    chk("mis_err",   {31'd0, err_o},        32'd1);
    chk("mis_req",   {31'd0, mem_req_o},    32'd0);
    chk("mis_stall", {31'd0, core_stall_o}, 32'd0);
    chk("mis_rd",    core_rd_o,             32'h77EF5A00);
    @(posedge clk);
    #1;
    core_req_i = 1'b0;
    @(negedge clk);
    chk("mis_idle_err", {31'd0, err_o},  32'd0);
    chk("mis_idle_rd",  core_rd_o,       32'h77EF5A00);
    @(posedge clk);
    #1;
`else
    access("lw11", 1'b0, 3'd2, 32'h11, 32'h0, 4'b1111, 32'h0, 32'h10, 32'hA1B2C3F4);
`endif

    // reset asserted during the WAIT cycle of a load
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h10;
    exp_q.push_back(32'hA1B2C3F4);
    @(negedge clk);
    chk("rstw_stall", {31'd0, core_stall_o}, 32'd1);
    @(posedge clk);
    #1;
    core_req_i = 1'b0;
    reset      = 1'b0;
    #1;
    chk("rstw_rd",    core_rd_o,              32'h0);
    chk("rstw_stall2",{31'd0, core_stall_o},  32'd0);
    chk("rstw_req",   {31'd0, mem_req_o},     32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rstw_idle_rd",  core_rd_o,             32'h0);
    chk("rstw_idle_req", {31'd0, mem_req_o},    32'd0);
    @(posedge clk);
    #1;
    access("lw_after_rst", 1'b0, 3'd1, 32'h12, 32'h0, 4'b1100, 32'h0, 32'h10, 32'hFFFFA1B2);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
